// File: rtl/signal_monitor.sv
// Output-side conflict monitor: registers the two light codes onto the lamps,
// and latches a sticky fault with flashing red until acknowledged and all-red is seen.
module signal_monitor #(
  parameter int Y2R_MIN   = 3,
  parameter int R2G_MIN   = 2,
  parameter int FLASH_DIV = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] highway,
  input  logic [1:0] country,
  input  logic       ack,
  output logic [1:0] lamp_hw,
  output logic [1:0] lamp_ct,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] DARK   = 2'd3;

  localparam int         FW         = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
  localparam logic [7:0] Y2R_MIN_C  = 8'(Y2R_MIN);
  localparam logic [7:0] R2G_MIN_C  = 8'(R2G_MIN);

  typedef enum logic [1:0] {S_MON, S_FAULT, S_RECOVER} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_prev_hw, r_prev_ct;
  logic [7:0]    r_dwell_hw, r_dwell_ct, r_allred;
  logic [7:0]    w_dwell_hw_nxt, w_dwell_ct_nxt, w_allred_nxt;
  logic [1:0]    r_lamp_hw, r_lamp_ct, w_lamp_hw_nxt, w_lamp_ct_nxt;
  logic          r_fault, w_fault_nxt;
  logic [2:0]    r_code, w_code_nxt, w_chk_code;
  logic [FW-1:0] r_flash_cnt, w_flash_cnt_nxt;
  logic          r_phase, w_phase_nxt;
  logic          w_conflict, w_illegal, w_bad_seq, w_short_y, w_short_c;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic bad_step(input logic [1:0] p, input logic [1:0] c);
    return (p == GREEN && c == RED) || (p == YELLOW && c == GREEN) ||
           (p == RED && c == YELLOW);
  endfunction

  always_comb begin
    w_dwell_hw_nxt = (highway != r_prev_hw) ? 8'd1 : sat_inc(r_dwell_hw);
    w_dwell_ct_nxt = (country != r_prev_ct) ? 8'd1 : sat_inc(r_dwell_ct);
    w_allred_nxt   = (highway == RED && country == RED) ? sat_inc(r_allred) : 8'd0;
  end

  // Checks compare the presented codes against history of earlier cycles only.
  always_comb begin
    w_conflict = (highway != RED) && (country != RED);
    w_illegal  = (highway == DARK) || (country == DARK);
    w_bad_seq  = bad_step(r_prev_hw, highway) || bad_step(r_prev_ct, country);
    w_short_y  = (r_prev_hw == YELLOW && highway == RED && r_dwell_hw < Y2R_MIN_C) ||
                 (r_prev_ct == YELLOW && country == RED && r_dwell_ct < Y2R_MIN_C);
    w_short_c  = ((r_prev_hw == RED && highway == GREEN) ||
                  (r_prev_ct == RED && country == GREEN)) && (r_allred < R2G_MIN_C);
    w_chk_code = 3'd0;
    if (w_conflict)     w_chk_code = 3'd1;
    else if (w_illegal) w_chk_code = 3'd2;
    else if (w_bad_seq) w_chk_code = 3'd3;
    else if (w_short_y) w_chk_code = 3'd4;
    else if (w_short_c) w_chk_code = 3'd5;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lamp_hw_nxt   = r_lamp_hw;
    w_lamp_ct_nxt   = r_lamp_ct;
    w_fault_nxt     = r_fault;
    w_code_nxt      = r_code;
    w_flash_cnt_nxt = r_flash_cnt;
    w_phase_nxt     = r_phase;
    case (r_state)
      S_MON: begin
        w_lamp_hw_nxt = highway;
        w_lamp_ct_nxt = country;
        if (w_chk_code != 3'd0) begin
          w_state_nxt     = S_FAULT;
          w_code_nxt      = w_chk_code;
          w_fault_nxt     = 1'b1;
          w_lamp_hw_nxt   = RED;
          w_lamp_ct_nxt   = RED;
          w_flash_cnt_nxt = '0;
          w_phase_nxt     = 1'b0;
        end
      end
      S_FAULT: begin
        if (ack) begin
          w_state_nxt   = S_RECOVER;
          w_lamp_hw_nxt = RED;
          w_lamp_ct_nxt = RED;
        end else if (r_flash_cnt == FLASH_LAST) begin
          w_flash_cnt_nxt = '0;
          w_phase_nxt     = ~r_phase;
          w_lamp_hw_nxt   = r_phase ? RED : DARK;
          w_lamp_ct_nxt   = r_phase ? RED : DARK;
        end else begin
          w_flash_cnt_nxt = r_flash_cnt + FW'(1);
          w_lamp_hw_nxt   = r_phase ? DARK : RED;
          w_lamp_ct_nxt   = r_phase ? DARK : RED;
        end
      end
      S_RECOVER: begin
        w_lamp_hw_nxt = RED;
        w_lamp_ct_nxt = RED;
        // Uses the count including this cycle so exit lands on the R2G_MIN-th all-red edge.
        if (w_allred_nxt >= R2G_MIN_C) begin
          w_state_nxt   = S_MON;
          w_fault_nxt   = 1'b0;
          w_code_nxt    = 3'd0;
          w_lamp_hw_nxt = highway;
          w_lamp_ct_nxt = country;
        end
      end
      default: w_state_nxt = S_MON;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_MON;
      r_prev_hw   <= RED;
      r_prev_ct   <= RED;
      r_dwell_hw  <= 8'd0;
      r_dwell_ct  <= 8'd0;
      r_allred    <= R2G_MIN_C;
      r_lamp_hw   <= RED;
      r_lamp_ct   <= RED;
      r_fault     <= 1'b0;
      r_code      <= 3'd0;
      r_flash_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_hw   <= highway;
      r_prev_ct   <= country;
      r_dwell_hw  <= w_dwell_hw_nxt;
      r_dwell_ct  <= w_dwell_ct_nxt;
      r_allred    <= w_allred_nxt;
      r_lamp_hw   <= w_lamp_hw_nxt;
      r_lamp_ct   <= w_lamp_ct_nxt;
      r_fault     <= w_fault_nxt;
      r_code      <= w_code_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  assign lamp_hw    = r_lamp_hw;
  assign lamp_ct    = r_lamp_ct;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule

// File: tb/tb_signal_monitor.sv
// Scoreboard bench for signal_monitor: each driven cycle queues the expected
// registered outputs, which the monitor pops one clock later.
module tb_signal_monitor;

  logic       clk;
  logic       clr;
  logic [1:0] highway, country;
  logic       ack;
  logic [1:0] lamp_hw, lamp_ct;
  logic       fault;
  logic [2:0] fault_code;

  typedef struct packed {
    logic [1:0] hw;
    logic [1:0] ct;
    logic       f;
    logic [2:0] code;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  logic started = 1'b0;

  signal_monitor #(.Y2R_MIN(3), .R2G_MIN(2), .FLASH_DIV(4)) dut (
    .clk(clk), .clr(clr), .highway(highway), .country(country), .ack(ack),
    .lamp_hw(lamp_hw), .lamp_ct(lamp_ct), .fault(fault), .fault_code(fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] hw, input logic [1:0] ct, input logic a,
                       input logic [1:0] ehw, input logic [1:0] ect,
                       input logic ef, input logic [2:0] ecode);
    exp_t x;
    @(negedge clk);
    clr = 1'b0; highway = hw; country = ct; ack = a;
    x.hw = ehw; x.ct = ect; x.f = ef; x.code = ecode;
    sb_q.push_back(x);
  endtask

  task automatic pass(input logic [1:0] hw, input logic [1:0] ct, input int n);
    repeat (n) drive(hw, ct, 1'b0, hw, ct, 1'b0, 3'd0);
  endtask

  task automatic do_clr(input logic [1:0] hw, input logic [1:0] ct);
    exp_t x;
    @(negedge clk);
    clr = 1'b1; highway = hw; country = ct; ack = 1'b0;
    x = '0;
    sb_q.push_back(x);
    started = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        n_pop++;
        check($sformatf("lamp_hw#%0d", n_pop), {6'd0, lamp_hw}, {6'd0, mon_e.hw});
        check($sformatf("lamp_ct#%0d", n_pop), {6'd0, lamp_ct}, {6'd0, mon_e.ct});
        check($sformatf("fault#%0d", n_pop), {7'd0, fault}, {7'd0, mon_e.f});
        check($sformatf("code#%0d", n_pop), {5'd0, fault_code}, {5'd0, mon_e.code});
      end
      if (started)
        check("lamp_invariant",
              {7'd0, (lamp_hw == 2'd0) || (lamp_ct == 2'd0) ||
                     (lamp_hw == 2'd3 && lamp_ct == 2'd3)}, 8'd1);
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; highway = 2'd0; country = 2'd0; ack = 1'b0;

    // Legal cycle: pass-through delayed by one clock, no fault.
    do_clr(2'd0, 2'd0);
    pass(2'd2, 2'd0, 10); pass(2'd1, 2'd0, 3); pass(2'd0, 2'd0, 2);
    pass(2'd0, 2'd2, 5);  pass(2'd0, 2'd1, 3); pass(2'd0, 2'd0, 2);
    pass(2'd2, 2'd0, 3);

    // Conflict, flash pattern, then acknowledge and recovery.
    drive(2'd2, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1);
    for (int i = 1; i < 12; i++)
      drive(2'd2, 2'd0, 1'b0, ((i / 4) % 2 == 1) ? 2'd3 : 2'd0,
            ((i / 4) % 2 == 1) ? 2'd3 : 2'd0, 1'b1, 3'd1);
    drive(2'd2, 2'd0, 1'b1, 2'd0, 2'd0, 1'b1, 3'd1);
    drive(2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1);
    drive(2'd2, 2'd0, 1'b1, 2'd0, 2'd0, 1'b1, 3'd1);
    drive(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1);
    drive(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0);
    pass(2'd0, 2'd0, 1); pass(2'd2, 2'd0, 3);

    // Conflict outranks illegal code.
    do_clr(2'd0, 2'd0);
    drive(2'd3, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1);
    drive(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1);

    // Short yellow.
    do_clr(2'd0, 2'd0);
    pass(2'd2, 2'd0, 3); pass(2'd1, 2'd0, 2);
    drive(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd4);

    // Green straight to red.
    do_clr(2'd0, 2'd0);
    pass(2'd2, 2'd0, 3);
    drive(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd3);

    // Illegal code alone; a later conflict must not overwrite the code.
    do_clr(2'd0, 2'd0);
    drive(2'd3, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd2);
    drive(2'd1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1, 3'd2);

    // Short clear after one all-red cycle.
    do_clr(2'd0, 2'd0);
    pass(2'd2, 2'd0, 3); pass(2'd1, 2'd0, 3); pass(2'd0, 2'd0, 1);
    drive(2'd0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1, 3'd5);

    // Two all-red cycles is enough.
    do_clr(2'd0, 2'd0);
    pass(2'd2, 2'd0, 3); pass(2'd1, 2'd0, 3); pass(2'd0, 2'd0, 2);
    pass(2'd0, 2'd2, 3);

    // Reset during the dark flash phase, then immediate highway green.
    do_clr(2'd0, 2'd0);
    drive(2'd2, 2'd2, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1);
    for (int i = 1; i < 6; i++)
      drive(2'd0, 2'd0, 1'b0, (i >= 4) ? 2'd3 : 2'd0,
            (i >= 4) ? 2'd3 : 2'd0, 1'b1, 3'd1);
    do_clr(2'd2, 2'd0);
    pass(2'd2, 2'd0, 3);

    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
